// File: rtl/ac_power_controller_pkg.sv
// -----------------------------------------------------------------------------
// ac_power_controller_pkg
// Shared constants and types for the AC compressor power controller.
//   AC_STATE_W        : width of the state code driven on ac_state_o
//   ac_state_e        : state codes OFF=0, ON=1, GRACE=2, LOCKOUT=3, ECO_HOLD=4
//   AC_GRACE_TICKS    : default grace period in tick_i pulses
//   AC_LOCKOUT_TICKS  : default compressor minimum-off time in tick_i pulses
//   ac_is_powered()   : true for the states in which the compressor runs
// -----------------------------------------------------------------------------
package ac_power_controller_pkg;

   localparam int AC_STATE_W       = 3;
   localparam int AC_GRACE_TICKS   = 30;
   localparam int AC_LOCKOUT_TICKS = 180;

   typedef enum logic [AC_STATE_W-1:0] {
      AC_ST_OFF      = 3'd0,
      AC_ST_ON       = 3'd1,
      AC_ST_GRACE    = 3'd2,
      AC_ST_LOCKOUT  = 3'd3,
      AC_ST_ECO_HOLD = 3'd4
   } ac_state_e;

   // Power stays on through GRACE so a brief economy request never cycles
   // the compressor.
   function automatic logic ac_is_powered(ac_state_e s);
      return (s == AC_ST_ON) || (s == AC_ST_GRACE);
   endfunction

endpackage

// File: rtl/ac_power_controller_tick_counter.sv
// -----------------------------------------------------------------------------
// ac_tick_counter
// Loadable down-counter advanced by a timebase strobe. Expire is combinational
// so the owning FSM can leave its state on the very edge of the final tick.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset, counter returns to RST_VAL
//   tick      : one-cycle timebase strobe, decrements the count
//   load      : load load_val this edge (wins over a coincident tick)
//   load_val  : value loaded on state entry
//   expire    : tick && cnt == 1
// -----------------------------------------------------------------------------
module ac_tick_counter #(
   parameter int CNT_W   = 8,
   parameter int RST_VAL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   // Load beats tick: a tick on the entry edge must not count toward the
   // period. Count parks at zero rather than wrapping while the owning
   // state ignores it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= CNT_W'(RST_VAL);
      end else if (load) begin
         cnt <= load_val;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/ac_power_controller.sv
// -----------------------------------------------------------------------------
// ac_power_controller
// Compressor power sequencer downstream of the economy-mode block. Applies a
// grace period before an economy shutdown and a minimum-off lockout after
// every power-down. Reset lands in LOCKOUT so the compressor is protected
// even when reset interrupts a running cycle.
//
// Build option: define AC_CTRL_GRACE_EN to build the GRACE state. Without it
// an economy request in ON shuts down immediately (eco flag set) and state
// code 2 never appears.
//
// Parameters:
//   GRACE_TICKS   : ticks close_ac_i must persist in ON before shutdown (>=1)
//   LOCKOUT_TICKS : ticks the compressor is held off after power-down (>=1)
//   CNT_W         : shared counter width, holds max of the two tick counts
// Ports:
//   clk_i          : system clock
//   rst_n_i        : asynchronous active-low reset
//   tick_i         : one-cycle timebase strobe, never high two cycles running
//   ac_request_i   : user/thermostat wants AC (level)
//   close_ac_i     : economy shutdown request (level)
//   ac_power_o     : compressor enable, high in ON and GRACE
//   ac_state_o     : current state code
//   eco_shutdown_o : AC is off because of an economy request
//   lockout_o      : minimum-off lockout active
// -----------------------------------------------------------------------------
module ac_power_controller
   import ac_power_controller_pkg::*;
#(
   parameter int GRACE_TICKS   = AC_GRACE_TICKS,
   parameter int LOCKOUT_TICKS = AC_LOCKOUT_TICKS,
   parameter int CNT_W         = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  tick_i,
   input  logic                  ac_request_i,
   input  logic                  close_ac_i,
   output logic                  ac_power_o,
   output logic [AC_STATE_W-1:0] ac_state_o,
   output logic                  eco_shutdown_o,
   output logic                  lockout_o
);

   ac_state_e        state, nxt_state;
   logic             eco_q, nxt_eco;
   logic             power_q, lockout_q;
   logic             cnt_load, cnt_expire;
   logic [CNT_W-1:0] cnt_load_val;

   // Next-state and eco-flag decision. Priority everywhere is
   // request drop > close request > counter expiry, which also means a
   // close_ac_i drop coinciding with the last grace tick keeps power on.
   always_comb begin
      nxt_state = state;
      nxt_eco   = eco_q;
      case (state)
         AC_ST_OFF: begin
            if (ac_request_i) begin
               if (close_ac_i) begin
                  nxt_state = AC_ST_ECO_HOLD;
                  nxt_eco   = 1'b1;
               end else begin
                  nxt_state = AC_ST_ON;
               end
            end
         end
         AC_ST_ON: begin
            if (!ac_request_i) begin
               nxt_state = AC_ST_LOCKOUT;
            end else if (close_ac_i) begin
`ifdef AC_CTRL_GRACE_EN
               nxt_state = AC_ST_GRACE;
`else
               nxt_state = AC_ST_LOCKOUT;
               nxt_eco   = 1'b1;
`endif
            end
         end
`ifdef AC_CTRL_GRACE_EN
         AC_ST_GRACE: begin
            if (!ac_request_i) begin
               nxt_state = AC_ST_LOCKOUT;
            end else if (!close_ac_i) begin
               nxt_state = AC_ST_ON;
            end else if (cnt_expire) begin
               nxt_state = AC_ST_LOCKOUT;
               nxt_eco   = 1'b1;
            end
         end
`endif
         AC_ST_LOCKOUT: begin
            // Inputs are deliberately ignored; OFF re-evaluates them.
            if (cnt_expire) nxt_state = AC_ST_OFF;
         end
         AC_ST_ECO_HOLD: begin
            if (!ac_request_i) begin
               nxt_state = AC_ST_OFF;
            end else if (!close_ac_i) begin
               nxt_state = AC_ST_ON;
            end
         end
         default: nxt_state = AC_ST_LOCKOUT;
      endcase
      if (nxt_state == AC_ST_ON) nxt_eco = 1'b0;
      if (!ac_request_i)         nxt_eco = 1'b0;
   end

   // Counter reloads only on entry to a timed state; leaving GRACE for ON
   // simply abandons whatever count remains.
   assign cnt_load     = (nxt_state != state) &&
                         ((nxt_state == AC_ST_LOCKOUT) || (nxt_state == AC_ST_GRACE));
   assign cnt_load_val = (nxt_state == AC_ST_GRACE) ? CNT_W'(GRACE_TICKS)
                                                    : CNT_W'(LOCKOUT_TICKS);

   ac_tick_counter #(
      .CNT_W   (CNT_W),
      .RST_VAL (LOCKOUT_TICKS)
   ) u_cnt (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .tick     (tick_i),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .expire   (cnt_expire)
   );

   // Outputs are registered alongside the state from the next-state decode,
   // so they change on the same edge as the state code.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= AC_ST_LOCKOUT;
         eco_q     <= 1'b0;
         power_q   <= 1'b0;
         lockout_q <= 1'b1;
      end else begin
         state     <= nxt_state;
         eco_q     <= nxt_eco;
         power_q   <= ac_is_powered(nxt_state);
         lockout_q <= (nxt_state == AC_ST_LOCKOUT);
      end
   end

   assign ac_power_o     = power_q;
   assign ac_state_o     = state;
   assign eco_shutdown_o = eco_q;
   assign lockout_o      = lockout_q;

endmodule

// File: tb/tb_ac_power_controller.sv
// -----------------------------------------------------------------------------
// tb_ac_power_controller
// Directed table of {req, close, cycles, expected state, expected eco} rows,
// GRACE_TICKS=3, LOCKOUT_TICKS=5, tick_i every 4th clock counted from reset
// release. Every cycle of a row is compared. Row set follows the
// AC_CTRL_GRACE_EN build option.
// -----------------------------------------------------------------------------
module tb_ac_power_controller;
   import ac_power_controller_pkg::*;

   localparam int GT = 3;
   localparam int LT = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       req = 1'b0;
   logic       close_ac = 1'b0;
   logic       ac_power;
   logic [2:0] ac_state;
   logic       eco;
   logic       lockout;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic seen_grace = 1'b0;

   typedef struct {
      logic       req;
      logic       close_ac;
      int         n;
      logic [2:0] st;
      logic       eco;
      string      name;
   } vec_t;

   vec_t tbl[$];

   ac_power_controller #(
      .GRACE_TICKS   (GT),
      .LOCKOUT_TICKS (LT),
      .CNT_W         (8)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .tick_i         (tick),
      .ac_request_i   (req),
      .close_ac_i     (close_ac),
      .ac_power_o     (ac_power),
      .ac_state_o     (ac_state),
      .eco_shutdown_o (eco),
      .lockout_o      (lockout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && ac_state == 3'd2) seen_grace = 1'b1;

   function automatic vec_t mk(logic r, logic c, int n, logic [2:0] st, logic e, string name);
      vec_t v;
      v.req = r; v.close_ac = c; v.n = n; v.st = st; v.eco = e; v.name = name;
      return v;
   endfunction

   task automatic check(string name, logic [2:0] act, logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_outs(string name, logic [2:0] st, logic e);
      check({name, ".state"},   ac_state, st);
      check({name, ".power"},   ac_power, 3'((st == 3'd1) || (st == 3'd2)));
      check({name, ".lockout"}, lockout,  3'(st == 3'd3));
      check({name, ".eco"},     eco,      3'(e));
   endtask

   task automatic apply(vec_t v);
      for (int i = 0; i < v.n; i++) begin
         tick     = (cyc % 4 == 3);
         req      = v.req;
         close_ac = v.close_ac;
         @(posedge clk);
         #1;
         cyc++;
         check_outs(v.name, v.st, v.eco);
      end
   endtask

   task automatic do_reset();
      tick = 1'b0; req = 1'b1; close_ac = 1'b0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 3'd3, 1'b0);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   // Lockout from reset: ticks at cyc 3,7,11,15 count 5->1, cyc 19 expires.
   task automatic restart_to_on(string tag);
      apply(mk(1, 0, 19, AC_ST_LOCKOUT, 0, {tag, "_lock_hold"}));
      apply(mk(1, 0, 1,  AC_ST_OFF,     0, {tag, "_lock_exp"}));
      apply(mk(1, 0, 1,  AC_ST_ON,      0, {tag, "_on"}));
   endtask

   initial begin
      do_reset();
      restart_to_on("start");

`ifdef AC_CTRL_GRACE_EN
      // Brief opening: GRACE entered cyc21, ticks 23/27 -> cnt 1, drop at 28.
      tbl.push_back(mk(1, 1, 1,  AC_ST_GRACE,    0, "brief_enter"));
      tbl.push_back(mk(1, 1, 6,  AC_ST_GRACE,    0, "brief_hold"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "brief_back"));
      // Sustained: GRACE at 29, ticks 31,35, expiry on 39.
      tbl.push_back(mk(1, 1, 1,  AC_ST_GRACE,    0, "sust_enter"));
      tbl.push_back(mk(1, 1, 9,  AC_ST_GRACE,    0, "sust_hold"));
      tbl.push_back(mk(1, 1, 1,  AC_ST_LOCKOUT,  1, "sust_cut"));
      tbl.push_back(mk(1, 1, 19, AC_ST_LOCKOUT,  1, "sust_lock"));
      tbl.push_back(mk(1, 1, 1,  AC_ST_OFF,      1, "sust_off"));
      tbl.push_back(mk(1, 1, 1,  AC_ST_ECO_HOLD, 1, "sust_hold_eco"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "sust_resume"));
      // User off during GRACE, on a tick cycle (63); lockout expires at 83.
      tbl.push_back(mk(1, 1, 1,  AC_ST_GRACE,    0, "uoff_enter"));
      tbl.push_back(mk(0, 1, 1,  AC_ST_LOCKOUT,  0, "uoff_cut"));
      tbl.push_back(mk(1, 0, 19, AC_ST_LOCKOUT,  0, "uoff_ignore"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_OFF,      0, "uoff_off"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "uoff_on"));
      // Race: close drops on the expiring tick (cyc 95).
      tbl.push_back(mk(1, 1, 1,  AC_ST_GRACE,    0, "race_enter"));
      tbl.push_back(mk(1, 1, 9,  AC_ST_GRACE,    0, "race_hold"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "race_keep_on"));
`else
      // Direct economy cut at 21, lockout ticks 23..35, expiry on 39.
      tbl.push_back(mk(1, 1, 1,  AC_ST_LOCKOUT,  1, "eco_cut"));
      tbl.push_back(mk(1, 1, 17, AC_ST_LOCKOUT,  1, "eco_lock"));
      tbl.push_back(mk(1, 1, 1,  AC_ST_OFF,      1, "eco_off"));
      tbl.push_back(mk(1, 1, 1,  AC_ST_ECO_HOLD, 1, "eco_hold"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "eco_resume"));
      // User off at 42; lockout ticks 43..55, expiry on 59.
      tbl.push_back(mk(0, 0, 1,  AC_ST_LOCKOUT,  0, "uoff_cut"));
      tbl.push_back(mk(1, 0, 16, AC_ST_LOCKOUT,  0, "uoff_ignore"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_OFF,      0, "uoff_off"));
      tbl.push_back(mk(1, 0, 1,  AC_ST_ON,       0, "uoff_on"));
      // Eco flag drops as soon as the request drops, even in lockout.
      tbl.push_back(mk(1, 1, 1,  AC_ST_LOCKOUT,  1, "clr_cut"));
      tbl.push_back(mk(0, 1, 1,  AC_ST_LOCKOUT,  0, "clr_req_low"));
`endif

      foreach (tbl[i]) apply(tbl[i]);

      // Reset mid-operation: cut power immediately, without a clock edge.
      do_reset();
      restart_to_on("pre");
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_reset", 3'd3, 1'b0);
      tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      restart_to_on("post");

`ifndef AC_CTRL_GRACE_EN
      check("no_grace_code", 3'(seen_grace), 3'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
